mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 12, data-memory word-address width; TIMEOUT_CYCLES, default 64, maximum wait-for-ack cycles.
REQ-002 Ports SHALL be (name direction width meaning):
 clock  input  1  single clock, rising edge
 reset  input  1  synchronous, active-high reset
 ir_in  input  32  instruction from X/M latch
 o_in  input  32  ALU result / address from X/M latch
 b_in  input  32  store data from X/M latch
 isRStatus_in  input  1  status-write flag from X/M latch
 rStatus_in  input  32  status value from X/M latch
 mem_req  output  1  data-memory request
 mem_we  output  1  1 = write, 0 = read
 mem_addr  output  ADDR_W  word address
 mem_wdata  output  32  store data
 mem_ack  input  1  memory completion, one-cycle pulse
 mem_rdata  input  32  load data, valid with mem_ack
 stall_out  output  1  freeze F/D/X stages and X/M latch
 ir_out, o_out, d_out  output  32 each  M/W instruction, ALU result, load data
 isRStatus_out  output  1  M/W status-write flag
 rStatus_out  output  32  M/W status value

Function
REQ-003 Opcode SHALL be ir_in[31:27]; 5'b01000 = lw, 5'b00111 = sw; all other opcodes are non-memory.
REQ-004 FSM states SHALL be IDLE, WAIT, DONE.
REQ-005 IDLE with non-memory opcode: on the next edge, ir_out/o_out/isRStatus_out/rStatus_out SHALL take the inputs, d_out = 0, stall_out = 0, state stays IDLE.
REQ-006 IDLE with lw/sw: stall_out SHALL assert combinationally in that cycle; on the edge, mem_addr = o_in[ADDR_W-1:0], mem_wdata = b_in, mem_we = (sw), ir/o/status operands are captured internally, and state goes to WAIT.
REQ-007 In WAIT, mem_req SHALL be 1 and stall_out SHALL be 1; mem_addr, mem_we and mem_wdata SHALL be held stable.
REQ-008 mem_ack in WAIT SHALL move the state to DONE on that edge; for lw, d_out = mem_rdata; for sw, d_out = 0; mem_req SHALL drop the next cycle.
REQ-009 In DONE, stall_out = 0, and the M/W outputs SHALL present the captured instruction for exactly one cycle; the next edge returns to IDLE and processes the current ir_in per REQ-005/006.
REQ-010 mem_ack outside WAIT SHALL be ignored.
REQ-011 Memory instructions SHALL have a latency of at least 2 cycles; non-memory instructions SHALL have a latency of 1 cycle.
REQ-012 While stall_out = 1, M/W outputs SHALL present ir = 0 (bubble) and isRStatus_out = 0.

Reset
REQ-013 reset SHALL force state = IDLE; all outputs 0; timeout counter 0; stall_out = 0.
REQ-014 reset during WAIT SHALL drop mem_req on the following cycle and SHALL discard the pending access without writing d_out.

Configuration
REQ-015 Macro MEM_TIMEOUT_EN SHALL enable a wait counter, cleared on entering WAIT and incremented each WAIT cycle.
REQ-016 With MEM_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES without mem_ack, the block SHALL go to DONE with isRStatus_out = 1, rStatus_out = 32'd6, d_out = 0, and mem_req SHALL be deasserted.
REQ-017 Without MEM_TIMEOUT_EN, WAIT SHALL persist until mem_ack, and the counter logic SHALL be absent.

Structure
REQ-018 Opcode constants (OP_LW, OP_SW), the state encoding, and the timeout status code 6 SHALL reside in shared package proc_pkg.
REQ-019 The M/W output register bank SHALL be one sub-module, mw_latch, reusing the codebase's register with writeEnable = 1.

Verification
REQ-020 add, ir_in = 32'h00000000 | opcode 0, o_in = 5 -> next cycle ir_out = ir_in, o_out = 5, stall_out = 0 throughout.
REQ-021 lw, o_in = 0x010, mem_ack 3 cycles later with rdata = 0xDEADBEEF -> mem_addr = 0x010, mem_we = 0, stall high 4 cycles, d_out = 0xDEADBEEF in DONE.
REQ-022 sw, o_in = 0x7FF, b_in = 0x12345678, immediate ack -> mem_we = 1, mem_wdata = 0x12345678, d_out = 0, one DONE cycle.
REQ-023 reset asserted in the second WAIT cycle -> mem_req = 0 on the next cycle, all outputs 0, the following add passes normally.
REQ-024 With MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, no ack -> after 4 WAIT cycles isRStatus_out = 1, rStatus_out = 6; a stray ack after that is ignored.
REQ-025 Back-to-back lw, lw -> the second access is issued only after the first DONE, with no lost or duplicated instruction.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode constants, memory-stage FSM encoding,
// the M/W register bundle and the memory-timeout status code.
package proc_pkg;

  localparam logic [4:0]  OP_LW          = 5'b01000;
  localparam logic [4:0]  OP_SW          = 5'b00111;
  localparam logic [31:0] TIMEOUT_STATUS = 32'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] o;
    logic [31:0] d;
    logic        is_rstatus;
    logic [31:0] rstatus;
  } mw_bundle_t;

  function automatic logic is_mem_op(input logic [4:0] opcode);
    return (opcode == OP_LW) || (opcode == OP_SW);
  endfunction

endpackage

// File: rtl/mw_latch.sv
// M/W pipeline latch: the whole bundle loads every cycle.
module mw_latch
  import proc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  mw_bundle_t d,
  output mw_bundle_t q
);

  register #(.W($bits(mw_bundle_t))) u_reg (
    .clock       (clock),
    .reset       (reset),
    .writeEnable (1'b1),
    .d           (d),
    .q           (q)
  );

endmodule

// File: rtl/register.sv
// Generic clock-enabled register with synchronous active-high reset.
module register #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         writeEnable,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock) begin
    if (reset)
      q <= '0;
    else if (writeEnable)
      q <= d;
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues lw/sw to data memory, stalls upstream while waiting.
// Define MEM_TIMEOUT_EN to add a wait-for-ack timeout that retires with status 6.
module mem_stage_ctrl
  import proc_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       ir_in,
  input  logic [31:0]       o_in,
  input  logic [31:0]       b_in,
  input  logic              isRStatus_in,
  input  logic [31:0]       rStatus_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              stall_out,
  output logic [31:0]       ir_out,
  output logic [31:0]       o_out,
  output logic [31:0]       d_out,
  output logic              isRStatus_out,
  output logic [31:0]       rStatus_out
);

  state_t            state, state_next;
  logic [31:0]       cap_ir, cap_o, cap_rstatus;
  logic              cap_is_rstatus, cap_is_lw;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              issue, stall, timeout_hit;
  mw_bundle_t        mw_d, mw_q;

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Memory request fields and the instruction operands are frozen at issue time.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q         <= '0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      cap_ir         <= '0;
      cap_o          <= '0;
      cap_is_rstatus <= 1'b0;
      cap_rstatus    <= '0;
      cap_is_lw      <= 1'b0;
    end else if (issue) begin
      addr_q         <= o_in[ADDR_W-1:0];
      we_q           <= (ir_in[31:27] == OP_SW);
      wdata_q        <= b_in;
      cap_ir         <= ir_in;
      cap_o          <= o_in;
      cap_is_rstatus <= isRStatus_in;
      cap_rstatus    <= rStatus_in;
      cap_is_lw      <= (ir_in[31:27] == OP_LW);
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset || issue)
      wait_cnt <= '0;
    else if (state == WAIT)
      wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No counter in this build; the parameter stays so both builds share one interface.
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // Anything that is not a retiring instruction reaches M/W as an all-zero bubble.
  always_comb begin
    state_next = state;
    mw_d       = '0;
    stall      = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem_op(ir_in[31:27])) begin
          stall      = 1'b1;
          issue      = 1'b1;
          state_next = WAIT;
        end else begin
          mw_d.ir         = ir_in;
          mw_d.o          = o_in;
          mw_d.is_rstatus = isRStatus_in;
          mw_d.rstatus    = rStatus_in;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_ack) begin
          state_next      = DONE;
          mw_d.ir         = cap_ir;
          mw_d.o          = cap_o;
          mw_d.d          = cap_is_lw ? mem_rdata : 32'd0;
          mw_d.is_rstatus = cap_is_rstatus;
          mw_d.rstatus    = cap_rstatus;
        end else if (timeout_hit) begin
          state_next      = DONE;
          mw_d.ir         = cap_ir;
          mw_d.o          = cap_o;
          mw_d.is_rstatus = 1'b1;
          mw_d.rstatus    = TIMEOUT_STATUS;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  mw_latch u_mw_latch (
    .clock (clock),
    .reset (reset),
    .d     (mw_d),
    .q     (mw_q)
  );

  assign mem_req       = (state == WAIT);
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign stall_out     = stall && !reset;
  assign ir_out        = mw_q.ir;
  assign o_out         = mw_q.o;
  assign d_out         = mw_q.d;
  assign isRStatus_out = mw_q.is_rstatus;
  assign rStatus_out   = mw_q.rstatus;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: cycle table plus reset/long-wait/timeout sequences.
// Compile with MEM_TIMEOUT_EN to exercise the timeout path.
module tb_mem_stage_ctrl;

  localparam logic [31:0] LW1  = 32'h4000_0001;
  localparam logic [31:0] LW2  = 32'h4000_0AAA;
  localparam logic [31:0] LW3  = 32'h4000_0BBB;
  localparam logic [31:0] SW1  = 32'h3800_0002;
  localparam logic [31:0] ADD1 = 32'h0000_0123;
  localparam logic [31:0] ADD2 = 32'h0800_0321;
  localparam logic [31:0] OPFF = 32'hF800_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ir_in, o_in, b_in, rStatus_in, mem_rdata;
  logic        isRStatus_in, mem_ack;
  logic        mem_req, mem_we, stall_out, isRStatus_out;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, ir_out, o_out, d_out, rStatus_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] ir, o, b;
    logic        isr;
    logic [31:0] rs;
    logic        ack;
    logic [31:0] rdata;
    logic        stall, req, we;
    logic [11:0] addr;
    logic [31:0] wdata, ir_o, o_o, d_o;
    logic        isr_o;
    logic [31:0] rs_o;
  } vec_t;

  vec_t tbl [19];

  always #5 clock = ~clock;

  mem_stage_ctrl #(.ADDR_W(12), .TIMEOUT_CYCLES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .ir_in         (ir_in),
    .o_in          (o_in),
    .b_in          (b_in),
    .isRStatus_in  (isRStatus_in),
    .rStatus_in    (rStatus_in),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .stall_out     (stall_out),
    .ir_out        (ir_out),
    .o_out         (o_out),
    .d_out         (d_out),
    .isRStatus_out (isRStatus_out),
    .rStatus_out   (rStatus_out)
  );

  task automatic setIn(input logic [31:0] ir, input logic [31:0] o, input logic [31:0] b,
                       input logic isr, input logic [31:0] rs, input logic ack, input logic [31:0] rdata);
    ir_in = ir; o_in = o; b_in = b; isRStatus_in = isr; rStatus_in = rs;
    mem_ack = ack; mem_rdata = rdata;
  endtask

  task automatic applyStimulus(input vec_t v);
    setIn(v.ir, v.o, v.b, v.isr, v.rs, v.ack, v.rdata);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkRow(input vec_t v, input int idx);
    checkOutput($sformatf("row%0d.stall", idx), 32'(stall_out), 32'(v.stall));
    checkOutput($sformatf("row%0d.req", idx), 32'(mem_req), 32'(v.req));
    checkOutput($sformatf("row%0d.we", idx), 32'(mem_we), 32'(v.we));
    checkOutput($sformatf("row%0d.addr", idx), 32'(mem_addr), 32'(v.addr));
    checkOutput($sformatf("row%0d.wdata", idx), mem_wdata, v.wdata);
    checkOutput($sformatf("row%0d.ir_out", idx), ir_out, v.ir_o);
    checkOutput($sformatf("row%0d.o_out", idx), o_out, v.o_o);
    checkOutput($sformatf("row%0d.d_out", idx), d_out, v.d_o);
    checkOutput($sformatf("row%0d.isr_out", idx), 32'(isRStatus_out), 32'(v.isr_o));
    checkOutput($sformatf("row%0d.rs_out", idx), rStatus_out, v.rs_o);
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    //          ir    o       b             isr rs      ack rdata           stall req we addr     wdata          ir_o  o_o     d_o            isr_o rs_o
    tbl[0]  = '{32'h0, 32'h5,   32'h0,        0, 32'h0,  0, 32'h0,          0, 0, 0, 12'h000, 32'h0,        32'h0, 32'h0,   32'h0,         0, 32'h0};
    tbl[1]  = '{ADD1,  32'h77,  32'h99,       1, 32'hA5, 0, 32'h0,          0, 0, 0, 12'h000, 32'h0,        32'h0, 32'h5,   32'h0,         0, 32'h0};
    tbl[2]  = '{LW1,   32'h10,  32'h55,       1, 32'h11, 0, 32'h0,          1, 0, 0, 12'h000, 32'h0,        ADD1,  32'h77,  32'h0,         1, 32'hA5};
    tbl[3]  = '{LW1,   32'h10,  32'h55,       1, 32'h11, 0, 32'h0,          1, 1, 0, 12'h010, 32'h55,       32'h0, 32'h0,   32'h0,         0, 32'h0};
    tbl[4]  = '{LW1,   32'h10,  32'h55,       1, 32'h11, 0, 32'h0,          1, 1, 0, 12'h010, 32'h55,       32'h0, 32'h0,   32'h0,         0, 32'h0};
    tbl[5]  = '{LW1,   32'h10,  32'h55,       1, 32'h11, 1, 32'hDEADBEEF,   1, 1, 0, 12'h010, 32'h55,       32'h0, 32'h0,   32'h0,         0, 32'h0};
    tbl[6]  = '{LW1,   32'h10,  32'h55,       1, 32'h11, 0, 32'hBAD0BAD0,   0, 0, 0, 12'h010, 32'h55,       LW1,   32'h10,  32'hDEADBEEF,  1, 32'h11};
    tbl[7]  = '{SW1,   32'h7FF, 32'h12345678, 0, 32'h0,  0, 32'h0,          1, 0, 0, 12'h010, 32'h55,       32'h0, 32'h0,   32'h0,         0, 32'h0};
    tbl[8]  = '{SW1,   32'h7FF, 32'h12345678, 0, 32'h0,  1, 32'hFFFFFFFF,   1, 1, 1, 12'h7FF, 32'h12345678, 32'h0, 32'h0,   32'h0,         0, 32'h0};
    tbl[9]  = '{SW1,   32'h7FF, 32'h12345678, 0, 32'h0,  0, 32'h0,          0, 0, 1, 12'h7FF, 32'h12345678, SW1,   32'h7FF, 32'h0,         0, 32'h0};
    tbl[10] = '{LW2,   32'h123, 32'h0,        0, 32'h0,  0, 32'h0,          1, 0, 1, 12'h7FF, 32'h12345678, 32'h0, 32'h0,   32'h0,         0, 32'h0};
    tbl[11] = '{LW2,   32'h123, 32'h0,        0, 32'h0,  1, 32'hCAFE,       1, 1, 0, 12'h123, 32'h0,        32'h0, 32'h0,   32'h0,         0, 32'h0};
    tbl[12] = '{LW2,   32'h123, 32'h0,        0, 32'h0,  0, 32'h0,          0, 0, 0, 12'h123, 32'h0,        LW2,   32'h123, 32'hCAFE,      0, 32'h0};
    tbl[13] = '{LW3,   32'h456, 32'h0,        0, 32'h0,  0, 32'h0,          1, 0, 0, 12'h123, 32'h0,        32'h0, 32'h0,   32'h0,         0, 32'h0};
    tbl[14] = '{LW3,   32'h456, 32'h0,        0, 32'h0,  1, 32'hBEEF,       1, 1, 0, 12'h456, 32'h0,        32'h0, 32'h0,   32'h0,         0, 32'h0};
    tbl[15] = '{LW3,   32'h456, 32'h0,        0, 32'h0,  0, 32'h0,          0, 0, 0, 12'h456, 32'h0,        LW3,   32'h456, 32'hBEEF,      0, 32'h0};
    tbl[16] = '{ADD2,  32'h9,   32'h0,        1, 32'h3,  1, 32'h12,         0, 0, 0, 12'h456, 32'h0,        32'h0, 32'h0,   32'h0,         0, 32'h0};
    tbl[17] = '{OPFF,  32'h1,   32'h0,        0, 32'h0,  0, 32'h0,          0, 0, 0, 12'h456, 32'h0,        ADD2,  32'h9,   32'h0,         1, 32'h3};
    tbl[18] = '{32'h0, 32'h0,   32'h0,        0, 32'h0,  0, 32'h0,          0, 0, 0, 12'h456, 32'h0,        OPFF,  32'h1,   32'h0,         0, 32'h0};

    // Reset with a load waiting at the input: stall must stay low while reset is high.
    reset = 1'b1;
    setIn(LW1, 32'h10, 32'h55, 1'b1, 32'h11, 1'b0, 32'h0);
    nextCycle();
    @(negedge clock);
    checkOutput("reset.stall", 32'(stall_out), 32'd0);
    checkOutput("reset.req", 32'(mem_req), 32'd0);
    checkOutput("reset.ir_out", ir_out, 32'd0);
    checkOutput("reset.d_out", d_out, 32'd0);
    checkOutput("reset.addr", 32'(mem_addr), 32'd0);
    nextCycle();
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(tbl[i]);
      @(negedge clock);
      checkRow(tbl[i], i);
      nextCycle();
    end

    // Reset in the second WAIT cycle, with an ack arriving in that same cycle.
    setIn(LW1, 32'h20, 32'h77, 1'b1, 32'h5, 1'b0, 32'h0);
    @(negedge clock);
    checkOutput("rstwait.issue_stall", 32'(stall_out), 32'd1);
    nextCycle();
    @(negedge clock);
    checkOutput("rstwait.w1_req", 32'(mem_req), 32'd1);
    checkOutput("rstwait.w1_addr", 32'(mem_addr), 32'h20);
    nextCycle();
    reset = 1'b1;
    setIn(LW1, 32'h20, 32'h77, 1'b1, 32'h5, 1'b1, 32'hDEAD);
    @(negedge clock);
    checkOutput("rstwait.w2_req", 32'(mem_req), 32'd1);
    checkOutput("rstwait.w2_stall", 32'(stall_out), 32'd0);
    nextCycle();
    reset = 1'b0;
    setIn(ADD1, 32'h5, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clock);
    checkOutput("rstwait.req", 32'(mem_req), 32'd0);
    checkOutput("rstwait.stall", 32'(stall_out), 32'd0);
    checkOutput("rstwait.addr", 32'(mem_addr), 32'd0);
    checkOutput("rstwait.wdata", mem_wdata, 32'd0);
    checkOutput("rstwait.ir_out", ir_out, 32'd0);
    checkOutput("rstwait.d_out", d_out, 32'd0);
    checkOutput("rstwait.isr_out", 32'(isRStatus_out), 32'd0);
    checkOutput("rstwait.rs_out", rStatus_out, 32'd0);
    nextCycle();
    setIn(32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clock);
    checkOutput("rstwait.add_ir", ir_out, ADD1);
    checkOutput("rstwait.add_o", o_out, 32'h5);
    checkOutput("rstwait.add_stall", 32'(stall_out), 32'd0);
    nextCycle();

`ifdef MEM_TIMEOUT_EN
    // No ack: after four WAIT cycles the access retires with status 6.
    setIn(LW1, 32'h30, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    nextCycle();
    for (int w = 0; w < 4; w++) begin
      @(negedge clock);
      checkOutput($sformatf("tmo.w%0d_req", w), 32'(mem_req), 32'd1);
      checkOutput($sformatf("tmo.w%0d_stall", w), 32'(stall_out), 32'd1);
      nextCycle();
    end
    setIn(LW1, 32'h30, 32'h0, 1'b0, 32'h0, 1'b1, 32'h77);
    @(negedge clock);
    checkOutput("tmo.done_req", 32'(mem_req), 32'd0);
    checkOutput("tmo.done_stall", 32'(stall_out), 32'd0);
    checkOutput("tmo.isr_out", 32'(isRStatus_out), 32'd1);
    checkOutput("tmo.rs_out", rStatus_out, 32'd6);
    checkOutput("tmo.d_out", d_out, 32'd0);
    checkOutput("tmo.ir_out", ir_out, LW1);
    nextCycle();
    setIn(32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h88);
    @(negedge clock);
    checkOutput("tmo.after_req", 32'(mem_req), 32'd0);
    checkOutput("tmo.after_stall", 32'(stall_out), 32'd0);
    checkOutput("tmo.after_ir", ir_out, 32'd0);
    nextCycle();
    setIn(32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clock);
    checkOutput("tmo.stray_d", d_out, 32'd0);
    checkOutput("tmo.stray_req", 32'(mem_req), 32'd0);
    nextCycle();
`else
    // Without the timeout a load waits indefinitely for its ack.
    setIn(LW1, 32'h30, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    nextCycle();
    for (int w = 0; w < 12; w++) begin
      @(negedge clock);
      checkOutput($sformatf("wait.w%0d_req", w), 32'(mem_req), 32'd1);
      checkOutput($sformatf("wait.w%0d_isr", w), 32'(isRStatus_out), 32'd0);
      nextCycle();
    end
    setIn(LW1, 32'h30, 32'h0, 1'b0, 32'h0, 1'b1, 32'h5A5A5A5A);
    @(negedge clock);
    checkOutput("wait.ack_req", 32'(mem_req), 32'd1);
    nextCycle();
    setIn(LW1, 32'h30, 32'h0, 1'b0, 32'h0, 1'b1, 32'h11);
    @(negedge clock);
    checkOutput("wait.done_d", d_out, 32'h5A5A5A5A);
    checkOutput("wait.done_ir", ir_out, LW1);
    checkOutput("wait.done_stall", 32'(stall_out), 32'd0);
    checkOutput("wait.done_req", 32'(mem_req), 32'd0);
    nextCycle();
    setIn(32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clock);
    checkOutput("wait.after_req", 32'(mem_req), 32'd0);
    checkOutput("wait.after_d", d_out, 32'd0);
    nextCycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
